// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Hazard and sequencing controller for the 5-stage pipelined ARM core.
// It drives the load enables and synchronous clears of the PC and the FD,
// DE, EM and MW pipeline registers. It selects E-stage operand forwarding.
// It freezes the whole pipeline while data memory is not ready, and it
// counts stall and flush events in saturating counters.
//
// Parameters
//   TIMEOUT_CYC : max consecutive memory-wait cycles before mem_err (>= 2)
//   CNT_W       : width of the saturating stall / flush event counters
//
// Ports
//   clk, reset           : rising-edge clock, synchronous active-high reset
//   ra1d, ra2d           : source registers of the Decode instruction
//   ra1e, ra2e           : source registers of the Execute instruction
//   wa3e, wa3m, wa3w     : destination register in Execute / Memory / Writeback
//   regwrite_m/_w        : Memory / Writeback instruction writes the regfile
//   memtoreg_e           : Execute instruction is a load
//   pcsrc_e              : taken branch / PC write resolved in Execute
//   mem_req_m            : Memory instruction accesses data memory
//   mem_ready_m          : data memory completes the access this cycle
//   en_pc..en_mw         : register load enables (1 = load)
//   clr_fd..clr_mw       : register synchronous clears (clear beats enable)
//   fwd_ae, fwd_be       : 00 regfile, 01 Writeback result, 10 Memory ALU result
//   mem_err              : sticky memory timeout flag
//   stall_cnt            : cycles with a load-use stall or a memory freeze
//   flush_cnt            : taken-branch flushes
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int TIMEOUT_CYC = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       ra1d,
    input  logic [3:0]       ra2d,
    input  logic [3:0]       ra1e,
    input  logic [3:0]       ra2e,
    input  logic [3:0]       wa3e,
    input  logic [3:0]       wa3m,
    input  logic [3:0]       wa3w,
    input  logic             regwrite_m,
    input  logic             regwrite_w,
    input  logic             memtoreg_e,
    input  logic             pcsrc_e,
    input  logic             mem_req_m,
    input  logic             mem_ready_m,
    output logic             en_pc,
    output logic             en_fd,
    output logic             en_de,
    output logic             en_em,
    output logic             en_mw,
    output logic             clr_fd,
    output logic             clr_de,
    output logic             clr_em,
    output logic             clr_mw,
    output logic [1:0]       fwd_ae,
    output logic [1:0]       fwd_be,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // The wait counter never needs to hold more than TIMEOUT_CYC-1.
    localparam int WAIT_W = $clog2(TIMEOUT_CYC);

    localparam logic [WAIT_W-1:0] WAIT_ZERO = WAIT_W'(0);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0]  CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b01,
        ST_ERR      = 2'b10
    } state_t;

    state_t            state_r;
    state_t            state_nx_s;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic [WAIT_W-1:0] wait_nx_s;
    logic              err_set_s;
    logic              mem_err_r;
    logic              freeze_s;
    logic              ld_match_s;
    logic              ldstall_s;
    logic              stall_evt_s;
    logic              flush_evt_s;
    logic [CNT_W-1:0]  stall_cnt_r;
    logic [CNT_W-1:0]  flush_cnt_r;

    // Forwarding source for one E operand. A Memory-stage producer is younger
    // than a Writeback one, so it wins. r15 is the PC and is never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [3:0] src,
        input logic       wr_m,
        input logic [3:0] dst_m,
        input logic       wr_w,
        input logic [3:0] dst_w
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (src == 4'hF) begin
            sel = 2'b00;
        end else if (wr_m && (dst_m == src)) begin
            sel = 2'b10;
        end else if (wr_w && (dst_w == src)) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // Saturating increment: the counter sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
        logic [CNT_W-1:0] res;
        if (&val) begin
            res = val;
        end else begin
            res = val + CNT_ONE;
        end
        return res;
    endfunction

    // Freeze and load-use detection. In MEM_WAIT the freeze releases in the
    // same cycle that ready returns, so a wait costs one cycle per ready-low
    // cycle and nothing more.
    always_comb begin
        freeze_s = 1'b1;
        case (state_r)
            ST_RUN:      freeze_s = mem_req_m & ~mem_ready_m;
            ST_MEM_WAIT: freeze_s = ~mem_ready_m;
            ST_ERR:      freeze_s = 1'b1;
            default:     freeze_s = 1'b1;
        endcase
        ld_match_s  = (wa3e == ra1d) | (wa3e == ra2d);
        // A taken branch puts the Decode instruction on the wrong path, so no stall.
        ldstall_s   = memtoreg_e & ld_match_s & ~pcsrc_e;
        stall_evt_s = ldstall_s | freeze_s;
        flush_evt_s = pcsrc_e & ~freeze_s;
    end

    // Memory-wait FSM next state and wait-counter update.
    always_comb begin
        state_nx_s = state_r;
        wait_nx_s  = wait_cnt_r;
        err_set_s  = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (mem_req_m && !mem_ready_m) begin
                    state_nx_s = ST_MEM_WAIT;
                    wait_nx_s  = WAIT_ONE;
                end else begin
                    state_nx_s = ST_RUN;
                    wait_nx_s  = WAIT_ZERO;
                end
            end
            ST_MEM_WAIT: begin
                if (mem_ready_m) begin
                    state_nx_s = ST_RUN;
                    wait_nx_s  = WAIT_ZERO;
                end else if (wait_cnt_r == WAIT_LAST) begin
                    state_nx_s = ST_ERR;
                    wait_nx_s  = WAIT_ZERO;
                    err_set_s  = 1'b1;
                end else begin
                    state_nx_s = ST_MEM_WAIT;
                    wait_nx_s  = wait_cnt_r + WAIT_ONE;
                end
            end
            ST_ERR: begin
                // Only reset leaves ERR.
                state_nx_s = ST_ERR;
                wait_nx_s  = WAIT_ZERO;
            end
            default: begin
                // An illegal encoding recovers to RUN; it is frozen meanwhile.
                state_nx_s = ST_RUN;
                wait_nx_s  = WAIT_ZERO;
            end
        endcase
    end

    // FSM state, wait counter and sticky error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_RUN;
            wait_cnt_r <= WAIT_ZERO;
            mem_err_r  <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            wait_cnt_r <= wait_nx_s;
            mem_err_r  <= mem_err_r | err_set_s;
        end
    end

    // Stall and flush event counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_r <= CNT_ZERO;
            flush_cnt_r <= CNT_ZERO;
        end else begin
            if (stall_evt_s) begin
                stall_cnt_r <= sat_inc(stall_cnt_r);
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (flush_evt_s) begin
                flush_cnt_r <= sat_inc(flush_cnt_r);
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end

    // Stage enables and clears, highest-priority condition first.
    always_comb begin
        en_pc  = 1'b1;
        en_fd  = 1'b1;
        en_de  = 1'b1;
        en_em  = 1'b1;
        en_mw  = 1'b1;
        clr_fd = 1'b0;
        clr_de = 1'b0;
        clr_em = 1'b0;
        clr_mw = 1'b0;
        if (reset) begin
            {en_pc, en_fd, en_de, en_em, en_mw} = 5'b00000;
            {clr_fd, clr_de, clr_em, clr_mw}    = 4'b1111;
        end else if (freeze_s) begin
            // Nothing moves; branch and load-use are re-evaluated once unfrozen.
            {en_pc, en_fd, en_de, en_em, en_mw} = 5'b00000;
            {clr_fd, clr_de, clr_em, clr_mw}    = 4'b0000;
        end else if (ldstall_s) begin
            // Hold F and D, let the load advance and insert a bubble into E.
            {en_pc, en_fd, en_de, en_em, en_mw} = 5'b00111;
            {clr_fd, clr_de, clr_em, clr_mw}    = 4'b0100;
        end else if (pcsrc_e) begin
            // PC loads the target; the two wrong-path instructions are squashed.
            {en_pc, en_fd, en_de, en_em, en_mw} = 5'b11111;
            {clr_fd, clr_de, clr_em, clr_mw}    = 4'b1100;
        end else begin
            {en_pc, en_fd, en_de, en_em, en_mw} = 5'b11111;
            {clr_fd, clr_de, clr_em, clr_mw}    = 4'b0000;
        end
    end

    // Operand forwarding selects; forced to the register file during reset.
    always_comb begin
        fwd_ae = 2'b00;
        fwd_be = 2'b00;
        if (reset) begin
            fwd_ae = 2'b00;
            fwd_be = 2'b00;
        end else begin
            fwd_ae = fwd_sel(ra1e, regwrite_m, wa3m, regwrite_w, wa3w);
            fwd_be = fwd_sel(ra2e, regwrite_m, wa3m, regwrite_w, wa3w);
        end
    end

    assign mem_err   = mem_err_r;
    assign stall_cnt = stall_cnt_r;
    assign flush_cnt = flush_cnt_r;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//
// Self-checking bench for pipe_hazard_ctrl. The driver applies one stimulus
// vector per cycle. It pushes the expected response from a behavioural model
// onto a scoreboard queue. A monitor pops and compares on every falling edge.
// A narrow counter width is used so that counter saturation is reachable.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    localparam int TO   = 16;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b1;
    always #5 clk = ~clk;

    logic          reset;
    logic [3:0]    ra1d, ra2d, ra1e, ra2e, wa3e, wa3m, wa3w;
    logic          regwrite_m, regwrite_w, memtoreg_e, pcsrc_e, mem_req_m, mem_ready_m;
    logic          en_pc, en_fd, en_de, en_em, en_mw;
    logic          clr_fd, clr_de, clr_em, clr_mw;
    logic [1:0]    fwd_ae, fwd_be;
    logic          mem_err;
    logic [CW-1:0] stall_cnt, flush_cnt;

    pipe_hazard_ctrl #(.TIMEOUT_CYC(TO), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .ra1d(ra1d), .ra2d(ra2d), .ra1e(ra1e), .ra2e(ra2e),
        .wa3e(wa3e), .wa3m(wa3m), .wa3w(wa3w),
        .regwrite_m(regwrite_m), .regwrite_w(regwrite_w), .memtoreg_e(memtoreg_e),
        .pcsrc_e(pcsrc_e), .mem_req_m(mem_req_m), .mem_ready_m(mem_ready_m),
        .en_pc(en_pc), .en_fd(en_fd), .en_de(en_de), .en_em(en_em), .en_mw(en_mw),
        .clr_fd(clr_fd), .clr_de(clr_de), .clr_em(clr_em), .clr_mw(clr_mw),
        .fwd_ae(fwd_ae), .fwd_be(fwd_be), .mem_err(mem_err),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    typedef struct {
        logic [3:0] ra1d, ra2d, ra1e, ra2e, wa3e, wa3m, wa3w;
        logic       rw_m, rw_w, mtr_e, pcsrc, req, ready, rst;
    } stim_t;

    typedef struct {
        logic [4:0] en;      // pc, fd, de, em, mw
        logic [3:0] clr;     // fd, de, em, mw
        logic [1:0] fa, fb;
        logic       chk_reg; // registered outputs known (a reset has happened)
        logic       err;
        int         stall, flush;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state: memory-busy bookkeeping and event tallies.
    bit   m_known = 1'b0;
    bit   m_err   = 1'b0;
    bit   m_wait  = 1'b0;
    int   m_low   = 0;
    int   m_stall = 0;
    int   m_flush = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Which producer, if any, should feed an E operand.
    function automatic logic [1:0] exp_fwd(input logic [3:0] src, input stim_t s);
        if (src == 4'd15) return 2'b00;
        if (s.rw_m && s.wa3m == src) return 2'b10;
        if (s.rw_w && s.wa3w == src) return 2'b01;
        return 2'b00;
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s.ra1d = 4'd0; s.ra2d = 4'd0; s.ra1e = 4'd0; s.ra2e = 4'd0;
        s.wa3e = 4'd0; s.wa3m = 4'd0; s.wa3w = 4'd0;
        s.rw_m = 1'b0; s.rw_w = 1'b0; s.mtr_e = 1'b0; s.pcsrc = 1'b0;
        s.req = 1'b0; s.ready = 1'b1; s.rst = 1'b0;
        return s;
    endfunction

    function automatic logic [3:0] rreg();
        int v;
        v = $urandom_range(0, 4);
        return (v == 4) ? 4'hF : 4'(v);
    endfunction

    function automatic stim_t rnd();
        stim_t s;
        s.ra1d = rreg(); s.ra2d = rreg(); s.ra1e = rreg(); s.ra2e = rreg();
        s.wa3e = rreg(); s.wa3m = rreg(); s.wa3w = rreg();
        s.rw_m  = 1'($urandom_range(0, 1));
        s.rw_w  = 1'($urandom_range(0, 1));
        s.mtr_e = ($urandom_range(0, 2) == 0);
        s.pcsrc = ($urandom_range(0, 5) == 0);
        s.req   = ($urandom_range(0, 2) == 0);
        s.ready = ($urandom_range(0, 7) != 0);
        s.rst   = ($urandom_range(0, 63) == 0);
        return s;
    endfunction

    // Apply one cycle of stimulus, predict the response, advance the model.
    task automatic step(input stim_t s);
        exp_t e;
        bit   frz, ld;
        reset = s.rst; ra1d = s.ra1d; ra2d = s.ra2d; ra1e = s.ra1e; ra2e = s.ra2e;
        wa3e = s.wa3e; wa3m = s.wa3m; wa3w = s.wa3w;
        regwrite_m = s.rw_m; regwrite_w = s.rw_w; memtoreg_e = s.mtr_e;
        pcsrc_e = s.pcsrc; mem_req_m = s.req; mem_ready_m = s.ready;
        e.chk_reg = m_known; e.err = m_err; e.stall = m_stall; e.flush = m_flush;
        if (s.rst) begin
            e.en = 5'b00000; e.clr = 4'b1111; e.fa = 2'b00; e.fb = 2'b00;
            m_known = 1'b1; m_err = 1'b0; m_wait = 1'b0;
            m_low = 0; m_stall = 0; m_flush = 0;
        end else begin
            frz  = m_err || ((m_wait || s.req) && !s.ready);
            ld   = s.mtr_e && (s.wa3e == s.ra1d || s.wa3e == s.ra2d) && !s.pcsrc;
            e.fa = exp_fwd(s.ra1e, s);
            e.fb = exp_fwd(s.ra2e, s);
            if (frz)          begin e.en = 5'b00000; e.clr = 4'b0000; end
            else if (ld)      begin e.en = 5'b00111; e.clr = 4'b0100; end
            else if (s.pcsrc) begin e.en = 5'b11111; e.clr = 4'b1100; end
            else              begin e.en = 5'b11111; e.clr = 4'b0000; end
            if ((frz || ld) && m_stall < CMAX) m_stall++;
            if (s.pcsrc && !frz && m_flush < CMAX) m_flush++;
            if (!m_err) begin
                if ((m_wait || s.req) && !s.ready) begin
                    m_low++;
                    m_wait = 1'b1;
                    if (m_low == TO) begin
                        m_err  = 1'b1;
                        m_wait = 1'b0;
                    end
                end else begin
                    m_low  = 0;
                    m_wait = 1'b0;
                end
            end
        end
        sbq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare the presented outputs with the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                check("en",  32'({en_pc, en_fd, en_de, en_em, en_mw}), 32'(e.en));
                check("clr", 32'({clr_fd, clr_de, clr_em, clr_mw}), 32'(e.clr));
                check("fwd", 32'({fwd_ae, fwd_be}), 32'({e.fa, e.fb}));
                if (e.chk_reg) begin
                    check("mem_err",   32'(mem_err),   32'(e.err));
                    check("stall_cnt", 32'(stall_cnt), 32'(e.stall));
                    check("flush_cnt", 32'(flush_cnt), 32'(e.flush));
                end
            end
        end
    end

    initial begin
        stim_t s;
        // Reset for three cycles, then a hazard-free flow.
        s = idle(); s.rst = 1'b1;
        repeat (3) step(s);
        check("rst_stall", 32'(stall_cnt), 32'd0);
        s = idle();
        step(s);
        step(s);
        check("run_en", 32'({en_pc, en_fd, en_de, en_em, en_mw}), 32'h1F);

        // Load-use stall lasts one cycle.
        s = idle(); s.rst = 1'b1; step(s);
        s = idle(); step(s);
        s.mtr_e = 1'b1; s.wa3e = 4'd3; s.ra1d = 4'd3; step(s);
        check("ld_stall_cnt", 32'(stall_cnt), 32'd1);
        s = idle(); step(s);

        // Taken branch with a load-use match: flush only.
        s = idle(); s.rst = 1'b1; step(s);
        s = idle(); s.mtr_e = 1'b1; s.wa3e = 4'd3; s.ra1d = 4'd3; s.pcsrc = 1'b1; step(s);
        check("br_flush_cnt", 32'(flush_cnt), 32'd1);
        check("br_stall_cnt", 32'(stall_cnt), 32'd0);

        // Forwarding priority and r15 exclusion.
        s = idle(); s.rw_m = 1'b1; s.wa3m = 4'd5; s.rw_w = 1'b1; s.wa3w = 4'd5;
        s.ra1e = 4'd5; s.ra2e = 4'd15; step(s);
        check("fwd_ae_mem", 32'(fwd_ae), 32'd2);
        s.wa3m = 4'd15; step(s);
        check("fwd_be_r15", 32'(fwd_be), 32'd0);
        check("fwd_ae_wb",  32'(fwd_ae), 32'd1);

        // Memory wait: three ready-low cycles, then ready.
        s = idle(); s.rst = 1'b1; step(s);
        s = idle(); s.req = 1'b1; s.ready = 1'b0;
        repeat (3) step(s);
        s.ready = 1'b1; step(s);
        check("mw_stall_cnt", 32'(stall_cnt), 32'd3);
        s = idle(); step(s);
        check("mw_run_en", 32'(en_pc), 32'd1);

        // Timeout: error is sticky, frozen, branches not counted, stall saturates.
        s = idle(); s.rst = 1'b1; step(s);
        s = idle(); s.req = 1'b1; s.ready = 1'b0;
        repeat (TO) step(s);
        check("to_err", 32'(mem_err), 32'd1);
        s = idle(); s.pcsrc = 1'b1;
        repeat (3) step(s);
        check("to_flush_cnt", 32'(flush_cnt), 32'd0);
        check("to_stall_sat", 32'(stall_cnt), 32'(CMAX));
        check("to_frozen_en", 32'(en_pc), 32'd0);
        s = idle(); s.rst = 1'b1; step(s);
        check("to_err_clr", 32'(mem_err), 32'd0);

        // Randomised traffic against the model.
        for (int i = 0; i < 1500; i++) step(rnd());
        s = idle(); step(s); step(s);
        check("sb_drain", 32'(sbq.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
